ofmap_writeback: RTL and testbench

Downstream stage of the PE array controller. Consumes the serialized 25-bit PE result stream of one output tile and requantizes each result to signed 8 bits with optional ReLU. Packs eight bytes into each 64-bit word and buffers words in a FIFO. Drives the external write port (write_o/Odata) and flags tile completion on end_conv.

---
 rtl/ofmap_writeback.sv | 165 ++++++++++++++++
 tb/tb_ofmap_writeback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback.sv
// Output-feature-map writeback: requantizes the serialized PE result stream to int8,
// packs PACK bytes per word, buffers words in a FIFO and signals tile completion.
module ofmap_writeback #(
  parameter int ACC_W      = 25,
  parameter int PACK       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [ACC_W-1:0]     res_data,
  input  logic                 res_last,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  output logic                 write_o,
  input  logic                 wr_ready,
  output logic [8*PACK-1:0]    Odata,
  output logic                 wr_last,
  output logic                 end_conv,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(PACK);
  localparam int DW = 8 * PACK;
  localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] QMAX = {{(ACC_W-7){1'b0}}, 8'h7F};
  localparam logic signed [ACC_W:0] QMIN = {{(ACC_W-7){1'b1}}, 8'h80};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nx;
  logic [4:0]        shift_q, eff_shift;
  logic              relu_q, eff_relu, starting, accept, pop, push;
  logic              s1_valid, s1_last, pk_valid, pk_last;
  logic [7:0]        s1_byte;
  logic [LW-1:0]     lane;
  logic [DW-1:0]     acc_word, acc_next, pk_word;
  logic [DW:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, free;
  logic              head_last;

  // ReLU, round-half-up arithmetic shift at ACC_W+1 bits, then saturate to int8.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] x, input logic [4:0] sh,
                                         input logic relu);
    logic signed [ACC_W:0] v;
    v = signed'({x[ACC_W-1], x});
    if (relu && v[ACC_W]) v = {(ACC_W+1){1'b0}};
    if (sh != 5'd0) v = (v + (ONE <<< (sh - 5'd1))) >>> sh;
    if (v > QMAX) return 8'h7F;
    else if (v < QMIN) return 8'h80;
    else return v[7:0];
  endfunction

  assign starting  = (state == IDLE) || (state == DONE);
  assign eff_shift = starting ? cfg_shift : shift_q;
  assign eff_relu  = starting ? cfg_relu : relu_q;
  assign free      = (AW+1)'(FIFO_DEPTH) - count;
  assign res_ready = (state != DRAIN) && (free >= (AW+1)'(3));
  assign accept    = res_valid && res_ready;
  assign write_o   = (count != {(AW+1){1'b0}});
  assign pop       = write_o && wr_ready;
  assign push      = pk_valid;
  assign head_last = mem[rd_ptr][DW];
  assign Odata     = write_o ? mem[rd_ptr][DW-1:0] : {DW{1'b0}};
  assign wr_last   = write_o ? head_last : 1'b0;
  assign end_conv  = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_next  = acc_word | (DW'(s1_byte) << {lane, 3'b000});

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = res_last ? DRAIN : RUN;
        else        state_nx = IDLE;
      end
      RUN: begin
        if (accept && res_last) state_nx = DRAIN;
        else                    state_nx = RUN;
      end
      DRAIN: begin
        if (pop && head_last) state_nx = DONE;
        else                  state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= 5'd0;
      relu_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (starting && accept) begin
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_byte  <= 8'h00;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_byte <= requant(res_data, eff_shift, eff_relu);
        s1_last <= res_last;
      end
    end
  end

  // Packer: a word closes on the last lane or on the tile's last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane     <= {LW{1'b0}};
      acc_word <= {DW{1'b0}};
      pk_valid <= 1'b0;
      pk_word  <= {DW{1'b0}};
      pk_last  <= 1'b0;
    end else begin
      pk_valid <= 1'b0;
      if (s1_valid) begin
        if ((lane == LW'(PACK-1)) || s1_last) begin
          pk_valid <= 1'b1;
          pk_word  <= acc_next;
          pk_last  <= s1_last;
          acc_word <= {DW{1'b0}};
          lane     <= {LW{1'b0}};
        end else begin
          acc_word <= acc_next;
          lane     <= lane + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pk_last, pk_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Self-checking bench for ofmap_writeback: constant vector table plus directed
// multi-cycle sequences, with a queue scoreboard of expected {wr_last, Odata}.
module tb_ofmap_writeback;

  logic        clk = 1'b0;
  logic        rst, res_valid, res_ready, res_last, cfg_relu;
  logic        write_o, wr_ready, wr_last, end_conv, busy;
  logic [24:0] res_data;
  logic [4:0]  cfg_shift;
  logic [63:0] Odata;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int ec_count = 0;
  logic [64:0] exp_q[$];
  logic [63:0] m_word = 64'd0;
  int          m_lane = 0;

  typedef struct {
    logic [24:0] data;
    logic [4:0]  shift;
    logic        relu;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  ofmap_writeback dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .write_o(write_o), .wr_ready(wr_ready), .Odata(Odata), .wr_last(wr_last),
    .end_conv(end_conv), .busy(busy)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: count accepts/pulses, score transferred words.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) accepted++;
      if (end_conv) ec_count++;
      if (write_o && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %h expected none", {wr_last, Odata});
        end else begin
          check("word", {wr_last, Odata}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [24:0] d, input logic last, input logic [7:0] eb);
    logic got;
    m_word = m_word | (64'(eb) << (8 * m_lane));
    m_lane++;
    if (m_lane == 8 || last) begin
      exp_q.push_back({last, m_word});
      m_word = 64'd0;
      m_lane = 0;
    end
    res_valid = 1'b1;
    res_data  = d;
    res_last  = last;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = res_ready;
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    res_last  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got no_accept expected accept");
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy && !write_o;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_ready"}, res_ready, 1'b1);
    check({tag, "_write_o"}, write_o, 1'b0);
    check({tag, "_Odata"}, Odata, 64'd0);
    check({tag, "_wr_last"}, wr_last, 1'b0);
    check({tag, "_end_conv"}, end_conv, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [63:0] snap;
    logic        seen_wo;
    int          acc0, ec0;
    logic [24:0] d;

    vecs[0]  = '{25'd0,          5'd0,  1'b0, 8'h00};
    vecs[1]  = '{-25'sd1,        5'd0,  1'b0, 8'hFF};
    vecs[2]  = '{-25'sd1,        5'd0,  1'b1, 8'h00};
    vecs[3]  = '{25'd1000,       5'd3,  1'b0, 8'h7D};
    vecs[4]  = '{25'd1024,       5'd3,  1'b0, 8'h7F};
    vecs[5]  = '{-25'sd1024,     5'd3,  1'b0, 8'h80};
    vecs[6]  = '{-25'sd1030,     5'd3,  1'b0, 8'h80};
    vecs[7]  = '{25'd3,          5'd1,  1'b0, 8'h02};
    vecs[8]  = '{-25'sd3,        5'd1,  1'b0, 8'hFF};
    vecs[9]  = '{25'd16777215,   5'd24, 1'b0, 8'h01};
    vecs[10] = '{-25'sd16777216, 5'd24, 1'b0, 8'hFF};
    vecs[11] = '{-25'sd16777216, 5'd0,  1'b1, 8'h00};
    vecs[12] = '{25'd16777215,   5'd0,  1'b0, 8'h7F};
    vecs[13] = '{-25'sd5,        5'd0,  1'b1, 8'h00};
    vecs[14] = '{25'd200,        5'd1,  1'b0, 8'h64};

    rst = 1'b1; res_valid = 1'b0; res_data = 25'd0; res_last = 1'b0;
    cfg_shift = 5'd0; cfg_relu = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // Test 1: 1..8, latency and end_conv/busy timing.
    for (int i = 1; i <= 8; i++) beat(25'(i), i == 8, 8'(i));
    check("t1_exp_word", exp_q[0], {1'b1, 64'h0807060504030201});
    @(negedge clk); check("t1_wo_t0", write_o, 1'b0);
    @(negedge clk); check("t1_wo_t1", write_o, 1'b0);
    @(negedge clk); check("t1_wo_t2", write_o, 1'b1);
    check("t1_busy_t2", busy, 1'b1);
    @(negedge clk); check("t1_endconv", end_conv, 1'b1);
    check("t1_busy_done", busy, 1'b1);
    @(negedge clk); check("t1_endconv_off", end_conv, 1'b0);
    check("t1_busy_off", busy, 1'b0);
    wait_idle();

    // Single-beat tiles from the vector table.
    for (int v = 0; v < 15; v++) begin
      cfg_shift = vecs[v].shift;
      cfg_relu  = vecs[v].relu;
      beat(vecs[v].data, 1'b1, vecs[v].exp_byte);
      wait_idle();
    end

    // Test 2: saturation.
    cfg_shift = 5'd0; cfg_relu = 1'b0;
    beat(25'd300, 1'b0, 8'h7F);
    beat(-25'sd300, 1'b0, 8'h80);
    beat(25'd127, 1'b0, 8'h7F);
    beat(-25'sd128, 1'b1, 8'h80);
    wait_idle();

    // Test 3: rounding; cfg changes after the first beat must be ignored.
    for (int r = 0; r < 2; r++) begin
      cfg_shift = 5'd2; cfg_relu = r[0];
      beat(25'd5, 1'b0, 8'h01);
      cfg_shift = 5'd0; cfg_relu = ~r[0];
      beat(25'd6, 1'b0, 8'h02);
      beat(-25'sd6, 1'b0, (r == 0) ? 8'hFF : 8'h00);
      beat(25'd7, 1'b1, 8'h02);
      wait_idle();
    end

    // Test 4: backpressure with a 200-beat tile.
    cfg_shift = 5'd0; cfg_relu = 1'b0;
    wr_ready = 1'b0;
    acc0 = accepted;
    ec0 = ec_count;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          d = 25'(((i * 37) % 256) - 128);
          beat(d, i == 199, d[7:0]);
        end
      end
      begin
        repeat (150) @(negedge clk);
        snap = Odata;
        repeat (150) @(negedge clk);
        check("t4_accepted_in_stall", 65'(accepted - acc0), 65'd114);
        check("t4_res_ready_low", res_ready, 1'b0);
        check("t4_write_o_high", write_o, 1'b1);
        check("t4_odata_stable", Odata, snap);
        check("t4_head_word", {wr_last, Odata}, exp_q[0]);
        @(posedge clk);
        #1 wr_ready = 1'b1;
      end
    join
    wait_idle();
    check("t4_end_conv_count", 65'(ec_count - ec0), 65'd1);

    // Test 5: partial final word.
    ec0 = ec_count;
    for (int i = 1; i <= 9; i++) beat(25'd1, i == 9, 8'h01);
    check("t5_word0", exp_q[0], {1'b0, 64'h0101010101010101});
    wait_idle();
    check("t5_end_conv_count", 65'(ec_count - ec0), 65'd1);

    // Test 6: reset mid-tile, then a fresh tile.
    for (int i = 0; i < 5; i++) beat(25'd3, 1'b0, 8'h03);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_word = 64'd0;
    m_lane = 0;
    @(negedge clk);
    check_reset_outputs("t6");
    ec0 = ec_count;
    seen_wo = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_wo = seen_wo | write_o;
    end
    check("t6_no_write_after_reset", seen_wo, 1'b0);
    check("t6_no_end_conv", 65'(ec_count - ec0), 65'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(25'(11 + i), i == 7, 8'(11 + i));
    check("t6_exp_word", exp_q[0], {1'b1, 64'h1211100F0E0D0C0B});
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
